// File: rtl/lsu_unit.sv
// RV32I load/store unit: single-outstanding req/gnt/rvalid data-memory port,
// store lane encoding, load extraction/extension and fault reporting.
module lsu_unit #(
   parameter bit STORE_WAIT_RESP = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid_i,
   input  logic        ex_is_store_i,
   input  logic [2:0]  ex_funct3_i,
   input  logic [31:0] ex_addr_i,
   input  logic [31:0] ex_wdata_i,
   output logic        lsu_ready_o,
   output logic        lsu_busy_o,
   output logic        done_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        err_illegal_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_wstrb_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i
);

   typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

   state_e      state_q, state_d;

   logic        accept;
   logic        illegal;
   logic        misaligned;
   logic        fault;
   logic [3:0]  enc_wstrb;
   logic [31:0] enc_wdata;

   logic        is_store_q;
   logic [2:0]  funct3_q;
   logic [1:0]  off_q;
   logic [29:0] addr_q;
   logic [3:0]  wstrb_q;
   logic [31:0] wdata_q;

   logic        done_q;
   logic        err_q;
   logic        err_illegal_q;
   logic [31:0] rdata_q;

   logic        fault_done;
   logic        store_gnt_done;
   logic        resp_done;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_data;

   assign accept = ex_valid_i && lsu_ready_o;

   // Illegal funct3 wins over misalignment when reporting.
   always_comb begin
      illegal = 1'b0;
      if (ex_is_store_i) begin
         illegal = !(ex_funct3_i inside {3'b000, 3'b001, 3'b010});
      end else begin
         illegal = !(ex_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end
      misaligned = ((ex_funct3_i[1:0] == 2'b01) && ex_addr_i[0]) ||
                   ((ex_funct3_i[1:0] == 2'b10) && (ex_addr_i[1:0] != 2'b00));
      fault = illegal || misaligned;
   end

   always_comb begin
      enc_wstrb = 4'b0000;
      enc_wdata = 32'h0;
      if (ex_is_store_i) begin
         case (ex_funct3_i[1:0])
            2'b00: begin
               enc_wstrb = 4'b0001 << ex_addr_i[1:0];
               enc_wdata = {4{ex_wdata_i[7:0]}};
            end
            2'b01: begin
               enc_wstrb = 4'b0011 << ex_addr_i[1:0];
               enc_wdata = {2{ex_wdata_i[15:0]}};
            end
            default: begin
               enc_wstrb = 4'b1111;
               enc_wdata = ex_wdata_i;
            end
         endcase
      end
   end

   // Request fields are captured at accept so they stay stable until grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_store_q <= 1'b0;
         funct3_q   <= 3'b000;
         off_q      <= 2'b00;
         addr_q     <= 30'h0;
         wstrb_q    <= 4'b0000;
         wdata_q    <= 32'h0;
      end else if (accept && !fault) begin
         is_store_q <= ex_is_store_i;
         funct3_q   <= ex_funct3_i;
         off_q      <= ex_addr_i[1:0];
         addr_q     <= ex_addr_i[31:2];
         wstrb_q    <= enc_wstrb;
         wdata_q    <= enc_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept && !fault) begin
               state_d = StReq;
            end
         end
         StReq: begin
            if (mem_gnt_i) begin
               state_d = (is_store_q && !STORE_WAIT_RESP) ? StIdle : StResp;
            end
         end
         StResp: begin
            if (mem_rvalid_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      lsu_ready_o = (state_q == StIdle);
      lsu_busy_o  = (state_q != StIdle) || ex_valid_i;
      mem_req_o   = (state_q == StReq);
      mem_we_o    = (state_q == StReq) && is_store_q;
   end

   assign mem_addr_o  = {addr_q, 2'b00};
   assign mem_wstrb_o = wstrb_q;
   assign mem_wdata_o = wdata_q;

   assign byte_sel = mem_rdata_i[{off_q, 3'b000} +: 8];
   assign half_sel = mem_rdata_i[{off_q[1], 4'b0000} +: 16];

   always_comb begin
      case (funct3_q)
         3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
         3'b100:  load_data = {24'h0, byte_sel};
         3'b101:  load_data = {16'h0, half_sel};
         default: load_data = mem_rdata_i;
      endcase
   end

   assign fault_done     = accept && fault;
   assign store_gnt_done = (state_q == StReq) && mem_gnt_i && is_store_q && !STORE_WAIT_RESP;
   assign resp_done      = (state_q == StResp) && mem_rvalid_i;

   // Completion results are registered; they hold until the next completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         err_illegal_q <= 1'b0;
         rdata_q       <= 32'h0;
      end else begin
         done_q <= fault_done || store_gnt_done || resp_done;
         if (fault_done) begin
            err_q         <= 1'b1;
            err_illegal_q <= illegal;
            rdata_q       <= 32'h0;
         end else if (store_gnt_done || resp_done) begin
            err_q         <= 1'b0;
            err_illegal_q <= 1'b0;
            rdata_q       <= is_store_q ? 32'h0 : load_data;
         end
      end
   end

   assign done_o        = done_q;
   assign err_o         = err_q;
   assign err_illegal_o = err_illegal_q;
   assign rdata_o       = rdata_q;

endmodule

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
- Load/store unit in the execute/writeback boundary of the 3-stage RV32I pipeline.
- Directly consumes the ALU `result` as the effective address, plus rs2 store data and funct3.
- Drives a single-outstanding request/grant/response data-memory port.
- Returns aligned, sign/zero-extended load data to writeback, and reports misaligned or illegal accesses.
- Stalls the pipeline while an access is in flight.

Parameters:
- STORE_WAIT_RESP, 0: 0 = a store completes on grant; 1 = a store also waits for `mem_rvalid_i`.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- ex_valid_i  in  1  execute stage presents a memory op
- ex_is_store_i  in  1  1 = store, 0 = load
- ex_funct3_i  in  3  RV32I size/sign field
- ex_addr_i  in  32  effective address (ALU result)
- ex_wdata_i  in  32  rs2 store data
- lsu_ready_o  in/out: out  1  unit can accept an op
- lsu_busy_o  out  1  stall request to pipeline
- done_o  out  1  one-cycle completion pulse
- rdata_o  out  32  extended load result, valid with `done_o` on loads
- err_o  out  1  access fault, valid with `done_o`
- err_illegal_o  out  1  1 = illegal funct3, 0 = misaligned; valid with `err_o`
- mem_req_o  out  1  memory request
- mem_we_o  out  1  write enable
- mem_addr_o  out  32  word-aligned address
- mem_wstrb_o  out  4  byte strobes
- mem_wdata_o  out  32  lane-replicated store data
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  response valid
- mem_rdata_i  in  32  read word

Behaviour:
- **Reset** (`rst_n` low, async):
  - State goes to IDLE.
  - `mem_req_o`, `done_o`, `err_o`, `err_illegal_o`, `mem_we_o`, `lsu_busy_o` = 0.
  - `rdata_o`, `mem_addr_o`, `mem_wdata_o` = 0; `mem_wstrb_o` = 0.
  - `lsu_ready_o` = 1 once out of reset.
  - Reset mid-access drops `mem_req_o` immediately. Any later `mem_rvalid_i` is ignored.
- **States:** IDLE, REQ, RESP.
  - `lsu_ready_o` = (state == IDLE).
  - `lsu_busy_o` = !IDLE, or (IDLE && `ex_valid_i`).
- **Accept:** `ex_valid_i` && `lsu_ready_o`. On accept, latch `is_store`, `funct3`, `addr`, `wdata`.
- **Legality:**
  - Loads: funct3 in {000,001,010,100,101}.
  - Stores: funct3 in {000,001,010}.
  - Anything else is illegal.
  - Misaligned: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Illegal takes priority over misaligned.
- **Fault path:**
  - Stay in IDLE; no memory request is ever issued.
  - Next cycle: `done_o`=1, `err_o`=1, `err_illegal_o` set accordingly, `rdata_o`=0.
- **Legal op:** IDLE→REQ. In REQ:
  - `mem_req_o`=1.
  - `mem_addr_o`={addr[31:2],2'b00}.
  - `mem_we_o`=is_store.
  - All request outputs are held stable until `mem_gnt_i`.
- **On grant:**
  - Load → RESP.
  - Store with STORE_WAIT_RESP=0 → IDLE, `done_o`=1 next cycle.
  - Store with STORE_WAIT_RESP=1 → RESP.
  - `mem_req_o` deasserts the cycle after grant.
- **RESP:** wait for `mem_rvalid_i`, then → IDLE. `done_o` is registered and pulses the next cycle, with `rdata_o` for loads.
- **Response timing:**
  - `mem_rvalid_i` is only honoured in RESP.
  - Memory never returns `rvalid` in the grant cycle.
  - `mem_rvalid_i` in IDLE/REQ is ignored.
- **Store encoding** (off = `addr[1:0]`):
  - SB: wstrb = 4'b0001<<off, wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 4'b0011<<off, wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 4'b1111, wdata = wdata.
  - Loads drive wstrb = 0.
- **Load extraction:**
  - byte = `rdata[8*off+:8]`; half = `rdata[16*addr[1]+:16]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- **Outputs between ops:**
  - `done_o` is high exactly one cycle per accepted op.
  - `rdata_o`/`err_o` hold until the next `done_o`.
- **Latency** (1-cycle grant):
  - Load: accept T0, req/gnt T1, rvalid T2, done T3.
  - Store (STORE_WAIT_RESP=0): done T2.
  - Fault: done T1.
- **Back-to-back:** a new op may be accepted in the same cycle `done_o` pulses (state is IDLE).

Test Plan:
- **LB sign-extend:** LB at addr 0x1003, funct3=000, rdata 0x80FF_1234 → `mem_addr_o`=0x1000, wstrb=0, `rdata_o`=0xFFFF_FF80, done at T3.
- **LHU / LH:** LHU at 0x2002, rdata 0xBEEF_0000 → `rdata_o`=0x0000_BEEF. LH with the same data → 0xFFFF_BEEF.
- **SB / SH / SW encoding:**
  - SB at 0x3001, data 0x0000_00AB → wstrb=0010, wdata=0xABAB_ABAB, we=1, done 1 cycle after gnt.
  - SH at 0x3002 → wstrb=1100.
  - SW → 1111.
- **Faults:**
  - LW at 0x4002 → no `mem_req_o` ever; done T1 with err=1, err_illegal=0.
  - Load funct3=011 → err=1, err_illegal=1.
- **Grant stall:** `mem_gnt_i` withheld 5 cycles → req/addr/wstrb/wdata stable throughout. A spurious `mem_rvalid_i` during REQ is ignored.
- **Reset mid-op:** `rst_n` pulsed low while in RESP → `mem_req_o`=0 and `lsu_ready_o`=1 immediately after release. A late `mem_rvalid_i` produces no `done_o`.
